// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: state encoding, instruction field positions and default widths
package mem_stage_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;
endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: saturating cycle counter, expired on the LIMIT-th enabled cycle; LIMIT 0 never expires
module mem_watchdog #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    expired = (LIMIT != 0) && en && (int'(cnt_q) >= LIMIT - 1);
    cnt_d = clr ? '0 : (en && !expired) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: unified memory port for the multicycle core; holds IR/MDR and stalls control while busy.
// Define MEM_ALIGN_CHECK_EN to trap misaligned accesses instead of forcing word alignment.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_access,
  input  logic              I_or_D,
  input  logic              Mem_Write,
  input  logic              IR_Write,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] ALU_Out,
  input  logic [DATA_W-1:0] B_Data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic [DATA_W-1:0] Instr,
  output logic [5:0]        Op,
  output logic [5:0]        Funct,
  output logic [DATA_W-1:0] MDR,
  output logic              stall,
  output logic              mem_timeout
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misalign_trap,
  output logic [ADDR_W-1:0] misalign_addr
`endif
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, sel_addr, issue_addr;
  logic [DATA_W-1:0] wdata_q, wdata_d, instr_q, instr_d, mdr_q, mdr_d;
  logic we_q, we_d, fetch_q, fetch_d, timeout_q, timeout_d;
  logic busy, expired, misaligned;
`ifdef MEM_ALIGN_CHECK_EN
  logic trap_q, trap_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
`endif

  assign busy = (state_q == REQ) || (state_q == WAIT_RSP);
  assign sel_addr = I_or_D ? ALU_Out : PC;
`ifdef MEM_ALIGN_CHECK_EN
  assign issue_addr = sel_addr;
  assign misaligned = |sel_addr[1:0];
`else
  assign issue_addr = sel_addr & ~ADDR_W'(3);
  assign misaligned = 1'b0;
`endif

  mem_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk(clk),
    .reset(reset),
    .clr(!busy),
    .en(busy),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    we_d = we_q;
    wdata_d = wdata_q;
    fetch_d = fetch_q;
    instr_d = instr_q;
    mdr_d = mdr_q;
    timeout_d = timeout_q;
`ifdef MEM_ALIGN_CHECK_EN
    trap_d = 1'b0;
    maddr_d = maddr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (mem_access && misaligned) begin
          state_d = DONE;
`ifdef MEM_ALIGN_CHECK_EN
          trap_d = 1'b1;
          maddr_d = issue_addr;
`endif
        end else if (mem_access) begin
          state_d = REQ;
          addr_d = issue_addr;
          we_d = Mem_Write;
          wdata_d = B_Data;
          fetch_d = IR_Write;
        end
      end
      // a handshake in the final watchdog cycle still completes normally
      REQ: begin
        state_d = mem_req_ready ? (we_q ? DONE : WAIT_RSP) : expired ? DONE : REQ;
        timeout_d = timeout_q | (!mem_req_ready && expired);
      end
      WAIT_RSP: begin
        state_d = (mem_rsp_valid || expired) ? DONE : WAIT_RSP;
        timeout_d = timeout_q | (!mem_rsp_valid && expired);
        instr_d = (mem_rsp_valid && fetch_q) ? mem_rsp_rdata : instr_q;
        mdr_d = (mem_rsp_valid && !fetch_q) ? mem_rsp_rdata : mdr_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      fetch_q <= 1'b0;
      instr_q <= '0;
      mdr_q <= '0;
      timeout_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      trap_q <= 1'b0;
      maddr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wdata_q <= wdata_d;
      fetch_q <= fetch_d;
      instr_q <= instr_d;
      mdr_q <= mdr_d;
      timeout_q <= timeout_d;
`ifdef MEM_ALIGN_CHECK_EN
      trap_q <= trap_d;
      maddr_q <= maddr_d;
`endif
    end
  end

  assign mem_req_valid = state_q == REQ;
  assign mem_req_we = we_q;
  assign mem_req_addr = addr_q;
  assign mem_req_wdata = wdata_q;
  assign Instr = instr_q;
  assign Op = instr_q[OP_MSB:OP_LSB];
  assign Funct = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign MDR = mdr_q;
  assign mem_timeout = timeout_q;
  // control must never see stall while the stage itself is held in reset
  assign stall = reset & ((state_q == IDLE) ? mem_access : busy);
`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_trap = trap_q;
  assign misalign_addr = maddr_q;
`endif
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized accesses against a transaction-level model of the memory stage
module tb_mem_access_stage;
  localparam int AW = 32, DW = 32, TO = 8;
  logic clk = 1'b0, reset = 1'b1;
  logic mem_access = 1'b0, I_or_D = 1'b0, Mem_Write = 1'b0, IR_Write = 1'b0;
  logic [AW-1:0] PC = '0, ALU_Out = '0;
  logic [DW-1:0] B_Data = '0, mem_rsp_rdata = '0;
  logic mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic mem_req_valid, mem_req_we, stall, mem_timeout;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata, Instr, MDR;
  logic [5:0] Op, Funct;
`ifdef MEM_ALIGN_CHECK_EN
  logic misalign_trap;
  logic [AW-1:0] misalign_addr;
`endif
  int tests = 0, fails = 0;
  logic [DW-1:0] m_instr = '0, m_mdr = '0;
  logic m_to = 1'b0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .mem_access(mem_access), .I_or_D(I_or_D), .Mem_Write(Mem_Write),
    .IR_Write(IR_Write), .PC(PC), .ALU_Out(ALU_Out), .B_Data(B_Data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata), .Instr(Instr), .Op(Op), .Funct(Funct), .MDR(MDR),
    .stall(stall), .mem_timeout(mem_timeout)
`ifdef MEM_ALIGN_CHECK_EN
    , .misalign_trap(misalign_trap), .misalign_addr(misalign_addr)
`endif
  );

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return a;
`else
    return a & 32'hFFFF_FFFC;
`endif
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
`ifdef MEM_ALIGN_CHECK_EN
    return $urandom & 32'hFFFF_FFFC;
`else
    return $urandom;
`endif
  endfunction

  task automatic access(input logic iod, input logic we, input logic ir, input logic [AW-1:0] pc_v,
                        input logic [AW-1:0] alu_v, input logic [DW-1:0] bd, input logic [DW-1:0] rd,
                        input int rdy_wait, input int rsp_wait);
    logic [AW-1:0] ea;
    int phase, waits, rw, scnt, exp_s;
    bit done;
    ea = exp_addr(iod ? alu_v : pc_v);
    exp_s = 1 + rdy_wait + 1 + (we ? 0 : rsp_wait + 1);
    phase = 0; waits = 0; rw = 0; scnt = 1; done = 0;
    @(negedge clk);
    mem_access = 1'b1; I_or_D = iod; Mem_Write = we; IR_Write = ir; PC = pc_v; ALU_Out = alu_v;
    B_Data = bd; mem_req_ready = 1'b0; mem_rsp_valid = 1'($urandom_range(0, 1)); mem_rsp_rdata = $urandom;
    #1;
    tests++;
    if (stall !== 1'b1 || mem_req_valid !== 1'b0) begin
      fails++; $display("FAIL issue: stall=%b valid=%b, want 1/0", stall, mem_req_valid);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall === 1'b0) begin done = 1; break; end
      scnt++;
      if (phase == 0) begin
        tests++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== ea || mem_req_we !== we || (we && mem_req_wdata !== bd)) begin
          fails++;
          $display("FAIL req_fields: valid=%b addr=%h we=%b wdata=%h, want 1 %h %b %h",
                   mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, ea, we, bd);
        end
        mem_rsp_valid = 1'($urandom_range(0, 1)); mem_rsp_rdata = $urandom;
        if (waits == rdy_wait) begin mem_req_ready = 1'b1; phase = we ? 2 : 1; end
        else begin mem_req_ready = 1'b0; waits++; end
      end else if (phase == 1) begin
        tests++;
        if (mem_req_valid !== 1'b0) begin
          fails++; $display("FAIL wait_valid: valid=%b, want 0", mem_req_valid);
        end
        mem_req_ready = 1'($urandom_range(0, 1));
        if (rw == rsp_wait) begin mem_rsp_valid = 1'b1; mem_rsp_rdata = rd; phase = 2; end
        else begin mem_rsp_valid = 1'b0; rw++; end
      end else begin
        break;
      end
    end
    if (!we) begin
      if (ir) m_instr = rd;
      else m_mdr = rd;
    end
    tests++;
    if (!done || scnt != exp_s) begin
      fails++; $display("FAIL latency: done=%0d stall_cycles=%0d, want 1 %0d", done, scnt, exp_s);
    end
    tests++;
    if (mem_req_valid !== 1'b0 || mem_timeout !== m_to) begin
      fails++; $display("FAIL done_state: valid=%b timeout=%b, want 0 %b", mem_req_valid, mem_timeout, m_to);
    end
    tests++;
    if (Instr !== m_instr || MDR !== m_mdr || Op !== m_instr[31:26] || Funct !== m_instr[5:0]) begin
      fails++; $display("FAIL regs: Instr=%h MDR=%h Op=%h Funct=%h, want %h %h", Instr, MDR, Op, Funct, m_instr, m_mdr);
    end
    mem_access = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = ~rd;
    @(negedge clk);
    tests++;
    if (stall !== 1'b0 || mem_req_valid !== 1'b0 || Instr !== m_instr || MDR !== m_mdr) begin
      fails++; $display("FAIL idle_after: stall=%b valid=%b Instr=%h MDR=%h, want 0 0 %h %h",
                        stall, mem_req_valid, Instr, MDR, m_instr, m_mdr);
    end
    mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    mem_access = 1'b1; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({mem_req_valid, mem_req_we, stall, mem_timeout} !== 4'b0 || mem_req_addr !== '0 ||
        mem_req_wdata !== '0 || Instr !== '0 || MDR !== '0) begin
      fails++; $display("FAIL reset_vals: valid=%b we=%b stall=%b to=%b addr=%h Instr=%h MDR=%h, want all 0",
                        mem_req_valid, mem_req_we, stall, mem_timeout, mem_req_addr, Instr, MDR);
    end
    mem_access = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    tests++;
    if (stall !== 1'b0 || mem_req_valid !== 1'b0) begin
      fails++; $display("FAIL reset_idle: stall=%b valid=%b, want 0 0", stall, mem_req_valid);
    end
  endtask

  task automatic test_fetch();
    access(1'b0, 1'b0, 1'b1, 32'h0000_0040, rnd_addr(), $urandom, 32'h0000_0020, 0, 0);
    tests++;
    if (Instr !== 32'h20 || Op !== 6'd0 || Funct !== 6'h20) begin
      fails++; $display("FAIL fetch_fields: Instr=%h Op=%h Funct=%h, want 20 0 20", Instr, Op, Funct);
    end
  endtask

  task automatic test_load();
    access(1'b1, 1'b0, 1'b0, rnd_addr(), 32'h0000_0100, $urandom, $urandom, 3, 1);
  endtask

  task automatic test_store();
    access(1'b1, 1'b1, 1'b0, rnd_addr(), rnd_addr(), 32'hCAFE_F00D, $urandom, 1, 0);
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic we_r, ir_r;
      we_r = 1'($urandom_range(0, 1));
      ir_r = we_r ? 1'b0 : 1'($urandom_range(0, 1));
      access(1'($urandom_range(0, 1)), we_r, ir_r, rnd_addr(), rnd_addr(), $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2));
    end
  endtask

  task automatic test_back_to_back();
    access(1'b0, 1'b0, 1'b1, rnd_addr(), rnd_addr(), $urandom, $urandom, 0, 0);
    access(1'b1, 1'b0, 1'b0, rnd_addr(), rnd_addr(), $urandom, $urandom, 0, 0);
    access(1'b1, 1'b1, 1'b0, rnd_addr(), rnd_addr(), $urandom, $urandom, 0, 0);
    access(1'b1, 1'b0, 1'b0, rnd_addr(), rnd_addr(), $urandom, $urandom, 0, 0);
  endtask

  task automatic test_timeout(input bit in_wait);
    int scnt, vcnt;
    bit done;
    @(negedge clk);
    mem_access = 1'b1; I_or_D = 1'b1; Mem_Write = 1'b0; IR_Write = 1'($urandom_range(0, 1));
    ALU_Out = rnd_addr(); PC = rnd_addr(); mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    scnt = 1; vcnt = 0; done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (stall === 1'b0) begin done = 1; break; end
      scnt++;
      if (mem_req_valid === 1'b1) vcnt++;
      mem_req_ready = in_wait && (c == 2);
    end
    m_to = 1'b1;
    tests++;
    if (!done || scnt != 1 + TO || vcnt != (in_wait ? 3 : TO)) begin
      fails++; $display("FAIL timeout_len: done=%0d stall_cycles=%0d valid_cycles=%0d, want 1 %0d %0d",
                        done, scnt, vcnt, 1 + TO, in_wait ? 3 : TO);
    end
    tests++;
    if (mem_timeout !== 1'b1 || mem_req_valid !== 1'b0 || Instr !== m_instr || MDR !== m_mdr) begin
      fails++; $display("FAIL timeout_flag: to=%b valid=%b Instr=%h MDR=%h, want 1 0 %h %h",
                        mem_timeout, mem_req_valid, Instr, MDR, m_instr, m_mdr);
    end
    mem_access = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = ~m_mdr;
    repeat (2) @(negedge clk);
    mem_rsp_valid = 1'b0;
    tests++;
    if (mem_timeout !== 1'b1 || stall !== 1'b0 || Instr !== m_instr || MDR !== m_mdr) begin
      fails++; $display("FAIL late_rsp: to=%b stall=%b Instr=%h MDR=%h, want 1 0 %h %h",
                        mem_timeout, stall, Instr, MDR, m_instr, m_mdr);
    end
  endtask

  task automatic test_reset_mid(input bit in_wait);
    @(negedge clk);
    mem_access = 1'b1; I_or_D = 1'b1; Mem_Write = 1'b0; IR_Write = 1'b0; ALU_Out = rnd_addr();
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_req_valid !== 1'b1) begin
      fails++; $display("FAIL rstmid_req: valid=%b, want 1", mem_req_valid);
    end
    mem_req_ready = in_wait;
    @(negedge clk);
    mem_req_ready = 1'b0;
    tests++;
    if (mem_req_valid !== logic'(!in_wait)) begin
      fails++; $display("FAIL rstmid_phase: valid=%b, want %b", mem_req_valid, !in_wait);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (mem_req_valid !== 1'b0 || stall !== 1'b0 || Instr !== '0 || MDR !== '0 || mem_timeout !== 1'b0) begin
      fails++; $display("FAIL rstmid_async: valid=%b stall=%b Instr=%h MDR=%h to=%b, want 0 0 0 0 0",
                        mem_req_valid, stall, Instr, MDR, mem_timeout);
    end
    mem_rsp_valid = 1'b1; mem_rsp_rdata = $urandom | 32'h1;
    repeat (2) @(negedge clk);
    mem_access = 1'b0; reset = 1'b1;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    m_instr = '0; m_mdr = '0; m_to = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_req_valid !== 1'b0 || stall !== 1'b0 || Instr !== '0 || MDR !== '0) begin
      fails++; $display("FAIL rstmid_after: valid=%b stall=%b Instr=%h MDR=%h, want 0 0 0 0",
                        mem_req_valid, stall, Instr, MDR);
    end
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_misalign();
    @(negedge clk);
    mem_access = 1'b1; I_or_D = 1'b1; Mem_Write = 1'b0; IR_Write = 1'b0; ALU_Out = 32'h0000_0102;
    #1;
    tests++;
    if (stall !== 1'b1 || mem_req_valid !== 1'b0) begin
      fails++; $display("FAIL mis_issue: stall=%b valid=%b, want 1 0", stall, mem_req_valid);
    end
    @(negedge clk);
    tests++;
    if (stall !== 1'b0 || mem_req_valid !== 1'b0 || misalign_trap !== 1'b1 || misalign_addr !== 32'h102 ||
        Instr !== m_instr || MDR !== m_mdr) begin
      fails++; $display("FAIL mis_done: stall=%b valid=%b trap=%b maddr=%h, want 0 0 1 102",
                        stall, mem_req_valid, misalign_trap, misalign_addr);
    end
    mem_access = 1'b0;
    @(negedge clk);
    tests++;
    if (misalign_trap !== 1'b0 || mem_req_valid !== 1'b0) begin
      fails++; $display("FAIL mis_pulse: trap=%b valid=%b, want 0 0", misalign_trap, mem_req_valid);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_fetch();
    test_load();
    test_store();
    test_random(12);
    test_back_to_back();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_random(4);
    test_reset_mid(1'b1);
    test_reset_mid(1'b0);
    test_random(4);
`ifdef MEM_ALIGN_CHECK_EN
    test_misalign();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
